// File: rtl/comm_pkg.sv
// Shared constants and types for the K=3 rate-1/2 convolutional encoder/framer.
package comm_pkg;

  localparam int FRAME_INFO_BITS = 6;
  localparam int TAIL_BITS       = 2;
  localparam int BLOCK_LEN       = 2 * (FRAME_INFO_BITS + TAIL_BITS);

  // Generator taps, MSB = current input u, then s1, then s2.
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ENC  = 1'b1
  } enc_state_e;

  function automatic logic tap_parity(input logic [2:0] taps, input logic [2:0] bits);
    return ^(taps & bits);
  endfunction

endpackage

// File: rtl/conv_k3_step.sv
// One combinational trellis step of the K=3 (7,5) code: outputs both coded bits
// and the next shift-register state for a single information bit.
module conv_k3_step
  import comm_pkg::*;
(
  input  logic u_i,
  input  logic s1_i,
  input  logic s2_i,
  output logic g0_o,
  output logic g1_o,
  output logic s1_next_o,
  output logic s2_next_o
);

  logic [2:0] reg_bits;

  assign reg_bits  = {u_i, s1_i, s2_i};
  assign g0_o      = tap_parity(G0, reg_bits);
  assign g1_o      = tap_parity(G1, reg_bits);
  assign s1_next_o = u_i;
  assign s2_next_o = s1_i;

endmodule

// File: rtl/conv_encoder_framer.sv
// Loads FRAME_INFO_BITS info bits, then emits one contiguous block of coded bits
// (info + zero tail, g0 then g1 per bit) while the next frame loads in parallel.
//
// state   | meaning
// ST_IDLE | no block in flight, waiting for the loader to fill
// ST_ENC  | emitting coded bit cnt_q of the current block
module conv_encoder_framer #(
  parameter int FRAME_INFO_BITS = comm_pkg::FRAME_INFO_BITS,
  parameter int TAIL_BITS       = comm_pkg::TAIL_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic data_o,
  output logic out_sop
);

  import comm_pkg::*;

  localparam int BLK_LEN = 2 * (FRAME_INFO_BITS + TAIL_BITS);
  localparam int CNT_W   = $clog2(BLK_LEN);
  localparam int IDX_W   = CNT_W - 1;
  localparam int UV_W    = 1 << IDX_W;
  localparam int LCNT_W  = $clog2(FRAME_INFO_BITS + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLK_LEN - 1);
  localparam logic [LCNT_W-1:0] FULL_CNT = LCNT_W'(FRAME_INFO_BITS);

  enc_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [LCNT_W-1:0]          load_cnt_q, load_cnt_d;
  logic [FRAME_INFO_BITS-1:0] load_buf_q, load_buf_d;
  logic [FRAME_INFO_BITS-1:0] frame_q, frame_d;
  logic                       s1_q, s1_d, s2_q, s2_d;

  logic             load_full;
  logic             accept;
  logic             transfer;
  logic [IDX_W-1:0] info_idx;
  logic [UV_W-1:0]  u_vec;
  logic             u;
  logic             g0, g1, s1_next, s2_next;

  assign load_full = (load_cnt_q == FULL_CNT);
  assign in_ready  = !load_full;
  assign accept    = in_valid && in_ready;

  // Zero-extending the frame supplies the tail bits for indices past the info bits.
  assign info_idx = cnt_q[CNT_W-1:1];
  assign u_vec    = UV_W'(frame_q);
  assign u        = u_vec[info_idx];

  conv_k3_step u_step (
    .u_i       (u),
    .s1_i      (s1_q),
    .s2_i      (s2_q),
    .g0_o      (g0),
    .g1_o      (g1),
    .s1_next_o (s1_next),
    .s2_next_o (s2_next)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_cnt_d = load_cnt_q;
    load_buf_d = load_buf_q;
    frame_d    = frame_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    transfer   = 1'b0;

    if (accept) begin
      load_buf_d[load_cnt_q] = in_bit;
      load_cnt_d             = load_cnt_q + LCNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (load_full) begin
          state_d  = ST_ENC;
          transfer = 1'b1;
        end
      end
      ST_ENC: begin
        if (cnt_q[0]) begin
          s1_d = s1_next;
          s2_d = s2_next;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          transfer = load_full;
          state_d  = load_full ? ST_ENC : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (transfer) begin
      frame_d    = load_buf_q;
      load_buf_d = '0;
      load_cnt_d = '0;
      cnt_d      = '0;
      s1_d       = 1'b0;
      s2_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      load_cnt_q <= '0;
      load_buf_q <= '0;
      frame_q    <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_cnt_q <= load_cnt_d;
      load_buf_q <= load_buf_d;
      frame_q    <= frame_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = (state_q == ST_ENC);
  assign data_o    = out_valid && (cnt_q[0] ? g1 : g0);
  assign out_sop   = out_valid && (cnt_q == '0);

endmodule
